// File: rtl/sipo_pkg.sv
// Shared types and helpers for the serial-in/parallel-out deserializer.
// Holds the FSM state encoding and the counter-width clog2 function.
package sipo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/sipo_bit_cnt.sv
// Frame bit counter for the deserializer.
// Ports: clk, rst (async active-low), i_clr, i_inc, o_tc (cnt==WIDTH-1).
module sipo_bit_cnt
  import sipo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CW    = clog2(WIDTH)
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_tc
);

  logic [CW-1:0] r_cnt;

  // Clear with increment lands on 1: a bit that restarts a frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_cnt <= '0;
    else if (i_clr)
      r_cnt <= CW'(i_inc);
    else if (i_inc)
      r_cnt <= r_cnt + CW'(1);
  end

  assign o_tc = (r_cnt == CW'(WIDTH - 1));

endmodule

// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out deserializer: WIDTH-bit words, one-cycle valid.
// Ports: clk, rst (async active-low), din, din_en, sync -> dout,
// dout_valid, busy, err. Macro SIPO_PARITY_EN adds an even-parity bit.
module sipo_deserializer
  import sipo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_en,
  input  logic             sync,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             busy,
  output logic             err
);

  state_t r_state, w_next;

  logic w_clr, w_inc, w_start;
  logic w_shift, w_done, w_tc;

  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] w_sr_sh;
  logic [WIDTH-1:0] w_sr_new;
  logic [WIDTH-1:0] w_word;

  sipo_bit_cnt #(
    .WIDTH(WIDTH)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .i_clr(w_clr),
    .i_inc(w_inc),
    .o_tc (w_tc)
  );

  always_comb begin
    if (MSB_FIRST) begin
      w_sr_sh  = {r_sr[WIDTH-2:0], din};
      w_sr_new = {{(WIDTH-1){1'b0}}, din};
    end else begin
      w_sr_sh  = {din, r_sr[WIDTH-1:1]};
      w_sr_new = {din, {(WIDTH-1){1'b0}}};
    end
  end

`ifdef SIPO_PARITY_EN
  // Data already sits in r_sr; the last bit is parity.
  assign w_word = r_sr;
`else
  assign w_word = w_sr_sh;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_state <= ST_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_clr   = 1'b0;
    w_inc   = 1'b0;
    w_start = 1'b0;
    w_shift = 1'b0;
    w_done  = 1'b0;
    if (sync) begin
      w_clr = 1'b1;
      if (din_en) begin
        w_inc   = 1'b1;
        w_start = 1'b1;
        w_next  = ST_SHIFT;
      end else begin
        w_next = ST_IDLE;
      end
    end else if (din_en) begin
      unique case (r_state)
        ST_IDLE: begin
          w_inc   = 1'b1;
          w_start = 1'b1;
          w_next  = ST_SHIFT;
        end
        ST_SHIFT: begin
          w_shift = 1'b1;
          if (w_tc) begin
            w_clr = 1'b1;
`ifdef SIPO_PARITY_EN
            w_next = ST_PARITY;
`else
            w_done = 1'b1;
            w_next = ST_IDLE;
`endif
          end else begin
            w_inc = 1'b1;
          end
        end
`ifdef SIPO_PARITY_EN
        ST_PARITY: begin
          w_clr  = 1'b1;
          w_done = 1'b1;
          w_next = ST_IDLE;
        end
`endif
        default: w_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_sr <= '0;
    else if (w_start)
      r_sr <= w_sr_new;
    else if (w_shift)
      r_sr <= w_sr_sh;
    else if (sync)
      r_sr <= '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      dout_valid <= w_done;
      busy       <= (w_next != ST_IDLE);
      if (w_done)
        dout <= w_word;
    end
  end

`ifdef SIPO_PARITY_EN
  logic r_err;

  // Even parity: data bits plus parity bit must XOR to 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_err <= 1'b0;
    else if (w_done)
      r_err <= (^r_sr) ^ din;
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_deserializer.sv
// Testbench for sipo_deserializer: MSB-first and LSB-first instances
// share stimulus; a scoreboard checks each word and its valid cycle.
module tb_sipo_deserializer;

`ifdef SIPO_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic din = 1'b0;
  logic din_en = 1'b0;
  logic sync = 1'b0;

  logic [7:0] dout_m, dout_l;
  logic v_m, v_l, b_m, b_l, e_m, e_l;

  sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .din(din), .din_en(din_en), .sync(sync),
    .dout(dout_m), .dout_valid(v_m), .busy(b_m), .err(e_m)
  );

  sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .din(din), .din_en(din_en), .sync(sync),
    .dout(dout_l), .dout_valid(v_l), .busy(b_l), .err(e_l)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] m;
    logic [7:0] l;
    logic       e;
    int         cyc;
  } exp_t;

  typedef struct {
    logic [7:0] w;
    logic       p;
    logic [7:0] em;
    logic [7:0] el;
    logic       ep;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[6];

  int errs = 0;
  int checks = 0;
  int cyc = 0;

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] x);
    checks++;
    if (a !== x) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", n, a, x);
    end
  endtask

  task automatic drive(input logic d, input logic en, input logic s);
    @(negedge clk);
    din = d;
    din_en = en;
    sync = s;
  endtask

  task automatic push(input logic [7:0] m, input logic [7:0] l,
                      input logic e);
    exp_t t;
    t.m = m;
    t.l = l;
    t.e = e;
    t.cyc = cyc + 1;
    sb.push_back(t);
  endtask

  task automatic send_word(input logic [7:0] w, input logic p,
                           input logic [7:0] em, input logic [7:0] el,
                           input logic ep);
    for (int i = 7; i >= 0; i--) drive(w[i], 1'b1, 1'b0);
    if (PAR) drive(p, 1'b1, 1'b0);
    push(em, el, PAR ? ep : 1'b0);
  endtask

  logic       exp_v;
  exp_t       cur;
  logic [7:0] last_m = '0;
  logic [7:0] last_l = '0;
  logic       last_e = 1'b0;

  always @(posedge clk) begin
    cyc++;
    #1;
    if (!rst) begin
      last_m = '0;
      last_l = '0;
      last_e = 1'b0;
    end else begin
      exp_v = (sb.size() > 0) && (sb[0].cyc == cyc);
      chk("valid_msb", v_m, exp_v);
      chk("valid_lsb", v_l, exp_v);
      if (exp_v) begin
        cur = sb.pop_front();
        chk("dout_msb", dout_m, cur.m);
        chk("dout_lsb", dout_l, cur.l);
        chk("err_msb", e_m, cur.e);
        chk("err_lsb", e_l, cur.e);
        last_m = cur.m;
        last_l = cur.l;
        last_e = cur.e;
      end else begin
        chk("hold_msb", dout_m, last_m);
        chk("hold_lsb", dout_l, last_l);
        chk("hold_err", e_m, last_e);
      end
      if (sb.size() > 0 && sb[0].cyc < cyc) begin
        errs++;
        checks++;
        $display("FAIL missed_word: got none expected %0h",
                 sb[0].m);
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    tbl[0] = '{w: 8'hA5, p: 1'b0, em: 8'hA5, el: 8'hA5, ep: 1'b0};
    tbl[1] = '{w: 8'hA5, p: 1'b1, em: 8'hA5, el: 8'hA5, ep: 1'b1};
    tbl[2] = '{w: 8'hC0, p: 1'b0, em: 8'hC0, el: 8'h03, ep: 1'b0};
    tbl[3] = '{w: 8'h01, p: 1'b1, em: 8'h01, el: 8'h80, ep: 1'b0};
    tbl[4] = '{w: 8'hFF, p: 1'b1, em: 8'hFF, el: 8'hFF, ep: 1'b1};
    tbl[5] = '{w: 8'h6E, p: 1'b0, em: 8'h6E, el: 8'h76, ep: 1'b1};

    @(posedge clk);
    #2;
    chk("rst_dout_msb", dout_m, 8'h00);
    chk("rst_dout_lsb", dout_l, 8'h00);
    chk("rst_valid", v_m, 1'b0);
    chk("rst_busy", b_m, 1'b0);
    chk("rst_err", e_m, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    for (int k = 0; k < 6; k++)
      send_word(tbl[k].w, tbl[k].p, tbl[k].em, tbl[k].el, tbl[k].ep);
    drive(1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    chk("idle_busy_msb", b_m, 1'b0);
    chk("idle_busy_lsb", b_l, 1'b0);

    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0);
    @(posedge clk);
    #2;
    chk("partial_busy", b_m, 1'b1);
    drive(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 7; i++) drive(1'b0, 1'b1, 1'b0);
    if (PAR) drive(1'b1, 1'b1, 1'b0);
    push(8'h80, 8'h01, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);

    for (int i = 7; i >= 0; i--) begin
      drive(i >= 4, 1'b1, 1'b0);
      if (!PAR && i == 0) push(8'hF0, 8'h0F, 1'b0);
      @(posedge clk);
      #2;
      if (i > 0 || PAR) chk("gap_busy_bit", b_m, 1'b1);
      drive(1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #2;
      if (i > 0 || PAR) chk("gap_busy_hold", b_l, 1'b1);
    end
    if (PAR) begin
      drive(1'b0, 1'b1, 1'b0);
      push(8'hF0, 8'h0F, 1'b0);
    end
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);

    drive(1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    @(posedge clk);
    #2;
    chk("pre_rst_busy", b_m, 1'b1);
    @(negedge clk);
    din_en = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("arst_dout_msb", dout_m, 8'h00);
    chk("arst_dout_lsb", dout_l, 8'h00);
    chk("arst_valid", v_m, 1'b0);
    chk("arst_busy_msb", b_m, 1'b0);
    chk("arst_busy_lsb", b_l, 1'b0);
    chk("arst_err", e_m, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    send_word(8'h3C, 1'b0, 8'h3C, 8'h3C, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    chk("end_busy", b_m, 1'b0);
    chk("sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/sipo_deserializer.md
# sipo_deserializer

Serial-in/parallel-out deserializer that consumes the single-bit registered stream produced by the D flip-flop stage and assembles it into WIDTH-bit words. Each completed word is presented with a one-cycle valid strobe. A small FSM with a bit counter tracks frame progress. The block sits directly downstream of the flip-flop stage, which drives `din` from its `q` output.

## Interface
- `WIDTH`, default 8: data bits per word; legal range 2..32.
- `MSB_FIRST`, default 1: 1 means the first received bit lands in `dout[WIDTH-1]`; 0 means it lands in `dout[0]`.

- `clk`  input  1  rising-edge clock; the only clock.
- `rst`  input  1  asynchronous, active-low reset.
- `din`  input  1  serial data bit (from the flip-flop stage `q`).
- `din_en`  input  1  `din` is valid this cycle; sampled at the rising edge.
- `sync`  input  1  synchronous start-of-frame; discards any partial word.
- `dout`  output  WIDTH  last completed word; holds between words.
- `dout_valid`  output  1  one-cycle pulse when `dout` is updated.
- `busy`  output  1  a frame is in progress.
- `err`  output  1  parity error flag for the current `dout` (see Configuration).

## Operation
- FSM states:
  - IDLE: waiting for the first bit.
  - SHIFT: collecting data bits.
  - PARITY: collecting the parity bit; exists only with the macro defined.
- Bit counter `cnt` has width clog2(WIDTH). A shift register holds the partial word.
- IDLE with `din_en=1`:
  - capture bit 0 into the shift register;
  - set `cnt=1`;
  - go to SHIFT.
- IDLE with `din_en=0`: stay in IDLE; no state changes.
- SHIFT with `din_en=1`:
  - shift `din` in at the position set by `MSB_FIRST`;
  - increment `cnt`.
- SHIFT, when the bit at `cnt==WIDTH-1` is captured:
  - without parity: load the full word into `dout`, pulse `dout_valid`, go to IDLE, clear `cnt`;
  - with parity: go to PARITY.
- SHIFT with `din_en=0`: hold all state; gaps of any length are allowed.
- PARITY with `din_en=1`:
  - compute `err` = XOR of the WIDTH data bits and the parity bit (even parity expected);
  - load `dout`, pulse `dout_valid`, go to IDLE.
- `sync=1` takes priority over frame progress:
  - discard the partial word and clear `cnt`;
  - if `din_en=1` in the same cycle, that bit becomes bit 0 of a new frame (state SHIFT, `cnt=1`);
  - otherwise go to IDLE.
- `sync` never disturbs `dout`, `err`, or a `dout_valid` already issued.
- Back-to-back frames: after the completing bit, the next cycle's `din_en` bit starts a new frame with no idle cycle required.
- `busy` = 1 in SHIFT and PARITY, 0 in IDLE. It is registered together with the state.

## Timing
- Reset values: `dout=0`, `dout_valid=0`, `busy=0`, `err=0`, state IDLE, `cnt=0`, shift register 0.
- Reset is asynchronous: assertion clears everything immediately, including mid-frame. The partial word is lost; no `dout_valid` is emitted.
- All outputs are registered.
- `dout` and `dout_valid` update on the same rising edge that samples the final bit. Latency is one clock from the final bit being presented to `dout_valid` high.
- `dout_valid` is high for exactly one cycle per completed word and is never high on two consecutive cycles.
- `dout` and `err` stay stable until the next `dout_valid`.

## Configuration
- `SIPO_PARITY_EN` defined:
  - PARITY state is present;
  - each frame is WIDTH+1 bits (data followed by an even-parity bit);
  - `err` is updated with every `dout_valid`.
- `SIPO_PARITY_EN` undefined:
  - no PARITY state;
  - each frame is WIDTH bits;
  - `err` is tied to 0.

## Structure
- Shared package/header `sipo_pkg`:
  - state encoding constants `ST_IDLE`, `ST_SHIFT`, `ST_PARITY`;
  - a clog2 function for the counter width.
- One sub-module, `sipo_bit_cnt`: the frame bit counter, with clear, increment, and terminal-count output; same clock and reset.
- The top level holds the FSM, the shift register, and the output registers.

## Test plan
- Default config, `MSB_FIRST=1`, bits 1,0,1,0,0,1,0,1 sent on consecutive `din_en` cycles -> `dout=8'hA5` with `dout_valid` high one cycle later for exactly one cycle; `busy` 0 afterwards.
- `MSB_FIRST=0`, same bit sequence -> `dout=8'hA5` bit-reversed, i.e. `8'hA5` with bit order swapped = `8'hA5`; then sequence 1,1,0,0,0,0,0,0 -> `dout=8'h03`.
- Send 3 bits, assert `sync` with `din_en=1` and `din=1`, then 7 more bits 0 -> exactly one `dout_valid`, `dout=8'h80` (MSB_FIRST); the partial word is never output.
- Send 4 bits, pull `rst` low asynchronously between edges -> all outputs 0 immediately; after release, a full 8-bit frame of `8'h3C` gives `dout=8'h3C`.
- `din_en` toggling 1/0 every cycle during a frame of `8'hF0` -> `dout=8'hF0` after 16 cycles; `busy` high throughout the frame.
- With `SIPO_PARITY_EN`: data `8'hA5` + parity 0 -> `err=0`; data `8'hA5` + parity 1 -> `err=1`. Two frames back-to-back give two `dout_valid` pulses 9 cycles apart.
